// File: rtl/regfile_writeback_arbiter_pkg.sv
// rtl/regfile_writeback_arbiter_pkg.sv - shared types for the register file writeback arbiter
package regfile_writeback_arbiter_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [4:0] {
        X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
        X8,  X9,  X10, X11, X12, X13, X14, X15,
        X16, X17, X18, X19, X20, X21, X22, X23,
        X24, X25, X26, X27, X28, X29, X30, X31
    } register_e;

    typedef struct packed {
        logic                 enable;
        register_e            address;
        logic [DataWidth-1:0] data;
    } register_file_write_t;

    typedef struct packed {
        register_e            address;
        logic [DataWidth-1:0] data;
    } writeback_request_t;

    function automatic int unsigned pointer_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin grant starting at a given pointer
module round_robin_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int unsigned Count    = 3,
    parameter int unsigned PtrWidth = pointer_width(Count)
) (
    input  logic [Count-1:0]    request_i,
    input  logic [PtrWidth-1:0] pointer_i,
    output logic [Count-1:0]    grant_o
);

    logic found;

    // First pass covers indices at or above the pointer, second pass wraps to the low indices.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < Count; i++) begin
            if (!found && request_i[i] && (PtrWidth'(i) >= pointer_i)) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int unsigned i = 0; i < Count; i++) begin
            if (!found && request_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - shares one register file write port between writeback producers
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int unsigned RequesterCount = 3,
    parameter int unsigned RegisterCount  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [RequesterCount-1:0] req_valid_i,
    output logic [RequesterCount-1:0] req_ready_o,
    input  register_e                 req_address_i [RequesterCount],
    input  logic [DataWidth-1:0]      req_data_i    [RequesterCount],
    output register_file_write_t      write_o,
    output logic [RegisterCount-1:0]  pending_o
);

    localparam int unsigned PtrWidth     = pointer_width(RequesterCount);
    localparam int unsigned RegisterSpan = 2 ** $bits(register_e);

    logic [RequesterCount-1:0] buf_valid_q, buf_valid_d;
    writeback_request_t        buf_q [RequesterCount];
    writeback_request_t        buf_d [RequesterCount];
    logic [PtrWidth-1:0]       pointer_q, pointer_d;
    register_file_write_t      write_q, write_d;
    logic [RequesterCount-1:0] grant;
    logic [RequesterCount-1:0] accept;
    logic [RegisterSpan-1:0]   pending_all;

    round_robin_arbiter #(
        .Count    (RequesterCount),
        .PtrWidth (PtrWidth)
    ) u_arbiter (
        .request_i (buf_valid_q),
        .pointer_i (pointer_q),
        .grant_o   (grant)
    );

    // A buffer being drained this cycle can refill on the same edge.
    assign req_ready_o = ~buf_valid_q | grant;
    assign accept      = req_valid_i & req_ready_o;
    assign write_o     = write_q;

    always_comb begin
        for (int unsigned i = 0; i < RequesterCount; i++) begin
            buf_valid_d[i] = buf_valid_q[i];
            buf_d[i]       = buf_q[i];
            if (accept[i] && (req_address_i[i] != X0)) begin
                buf_valid_d[i]   = 1'b1;
                buf_d[i].address = req_address_i[i];
                buf_d[i].data    = req_data_i[i];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
    end

    // Address and data hold when idle; only enable drops.
    always_comb begin
        write_d        = write_q;
        write_d.enable = 1'b0;
        pointer_d      = pointer_q;
        for (int unsigned i = 0; i < RequesterCount; i++) begin
            if (grant[i]) begin
                write_d.enable  = 1'b1;
                write_d.address = buf_q[i].address;
                write_d.data    = buf_q[i].data;
                pointer_d       = (i == RequesterCount - 1) ? '0 : PtrWidth'(i + 1);
            end
        end
    end

    always_comb begin
        pending_all = '0;
        for (int unsigned i = 0; i < RequesterCount; i++) begin
            if (buf_valid_q[i]) begin
                pending_all[buf_q[i].address] = 1'b1;
            end
        end
        if (write_q.enable) begin
            pending_all[write_q.address] = 1'b1;
        end
        pending_o = pending_all[RegisterCount-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= '0;
            pointer_q   <= '0;
            write_q     <= '0;
            for (int unsigned i = 0; i < RequesterCount; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            pointer_q   <= pointer_d;
            write_q     <= write_d;
            for (int unsigned i = 0; i < RequesterCount; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    a_single_grant : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant));
    a_no_x0_write  : assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(write_o.enable && (write_o.address == X0)));

    for (genvar i = 0; i < RequesterCount; i++) begin : g_stable
        a_stable_request : assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[i] && !req_ready_o[i]) |=>
            ($stable(req_address_i[i]) && $stable(req_data_i[i])));
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - directed scoreboard bench for the writeback arbiter
module tb_regfile_writeback_arbiter;
    import regfile_writeback_arbiter_pkg::*;

    logic                 clk_i;
    logic                 rst_i;
    logic [2:0]           req_valid_i;
    logic [2:0]           req_ready_o;
    register_e            req_address_i [3];
    logic [31:0]          req_data_i    [3];
    register_file_write_t write_o;
    logic [31:0]          pending_o;

    int n_assert = 0;
    int n_fail   = 0;
    writeback_request_t sb [$];

    regfile_writeback_arbiter #(
        .RequesterCount (3),
        .RegisterCount  (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_address_i (req_address_i),
        .req_data_i    (req_data_i),
        .write_o       (write_o),
        .pending_o     (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input int addr, input logic [31:0] data);
        logic [4:0] a;
        a                = addr[4:0];
        req_valid_i[i]   = v;
        req_address_i[i] = register_e'(a);
        req_data_i[i]    = data;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        writeback_request_t e;
        logic [4:0] a;
        a         = addr[4:0];
        e.address = register_e'(a);
        e.data    = data;
        sb.push_back(e);
    endtask

    // Every committed write must match the next scoreboard entry.
    always @(negedge clk_i) begin
        if (!rst_i && write_o.enable) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'(write_o.enable), 64'd0);
            end else begin
                writeback_request_t e;
                e = sb.pop_front();
                check("wb_addr", 64'(write_o.address), 64'(e.address));
                check("wb_data", 64'(write_o.data), 64'(e.data));
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            req_address_i[i] = X0;
            req_data_i[i]    = '0;
        end

        tick();
        tick();
        check("reset_enable", 64'(write_o.enable), 64'd0);
        check("reset_write", 64'(write_o), 64'd0);
        check("reset_pending", 64'(pending_o), 64'd0);
        rst_i = 1'b0;
        check("reset_ready", 64'(req_ready_o), 64'b111);

        // Contention: all three continuously valid for six edges.
        drive(0, 1'b1, 1, 32'h11);
        drive(1, 1'b1, 2, 32'h22);
        drive(2, 1'b1, 3, 32'h33);
        for (int k = 0; k < 8; k++) begin
            expect_write(k % 3 + 1, 32'h11 * (k % 3 + 1));
        end
        check("cont_ready_initial", 64'(req_ready_o), 64'b111);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("cont_ready_rotation", 64'(req_ready_o), 64'(3'b001 << ((k - 1) % 3)));
        end
        req_valid_i = '0;
        tick();
        tick();
        tick();
        tick();
        check("cont_drained_enable", 64'(write_o.enable), 64'd0);
        check("cont_drained_pending", 64'(pending_o), 64'd0);

        // Single request with two-cycle latency.
        drive(1, 1'b1, 5, 32'hDEADBEEF);
        expect_write(5, 32'hDEADBEEF);
        check("single_ready", 64'(req_ready_o[1]), 64'd1);
        tick();
        req_valid_i = '0;
        check("single_pending_buf", 64'(pending_o), 64'(32'd1 << 5));
        check("single_not_yet", 64'(write_o.enable), 64'd0);
        tick();
        check("single_write", 64'(write_o), {23'd0, 1'b1, 5'd5, 32'hDEADBEEF});
        check("single_pending_out", 64'(pending_o), 64'(32'd1 << 5));
        tick();
        check("single_done_enable", 64'(write_o.enable), 64'd0);
        check("single_done_pending", 64'(pending_o), 64'd0);

        // Back-to-back stream from requester 2.
        for (int k = 0; k < 4; k++) begin
            drive(2, 1'b1, 10 + k, 32'hB0 + 32'(k));
            expect_write(10 + k, 32'hB0 + 32'(k));
            check("b2b_ready", 64'(req_ready_o[2]), 64'd1);
            tick();
        end
        req_valid_i = '0;
        check("b2b_third", 64'(write_o.address), 64'(X12));
        tick();
        check("b2b_fourth_enable", 64'(write_o.enable), 64'd1);
        check("b2b_fourth", 64'(write_o.address), 64'(X13));
        tick();
        check("b2b_idle", 64'(write_o.enable), 64'd0);

        // x0 writes are swallowed.
        drive(0, 1'b1, 0, 32'h1234);
        drive(1, 1'b1, 7, 32'h55);
        expect_write(7, 32'h55);
        check("x0_ready", 64'(req_ready_o[1:0]), 64'b11);
        tick();
        req_valid_i = '0;
        check("x0_pending", 64'(pending_o), 64'(32'd1 << 7));
        tick();
        check("x0_write_addr", 64'(write_o.address), 64'(X7));
        check("x0_pending_bit0", 64'(pending_o[0]), 64'd0);
        tick();
        check("x0_idle", 64'(write_o.enable), 64'd0);
        check("x0_pending_clear", 64'(pending_o), 64'd0);

        // Duplicate destination; pointer sits at 2 so requester 2 goes first.
        drive(0, 1'b1, 9, 32'h900);
        drive(2, 1'b1, 9, 32'h902);
        expect_write(9, 32'h902);
        expect_write(9, 32'h900);
        tick();
        req_valid_i = '0;
        check("dup_pending_a", 64'(pending_o), 64'(32'd1 << 9));
        tick();
        check("dup_first", 64'(write_o.data), 64'h902);
        check("dup_pending_b", 64'(pending_o), 64'(32'd1 << 9));
        tick();
        check("dup_second", 64'(write_o.data), 64'h900);
        check("dup_pending_c", 64'(pending_o), 64'(32'd1 << 9));
        tick();
        check("dup_pending_clear", 64'(pending_o), 64'd0);

        // Asynchronous reset with buffers and output register occupied.
        drive(0, 1'b1, 4, 32'h44);
        drive(1, 1'b1, 6, 32'h66);
        drive(2, 1'b1, 8, 32'h88);
        tick();
        req_valid_i = '0;
        tick();
        check("midrst_before_write", 64'(write_o.address), 64'(X6));
        check("midrst_before_pending", 64'(pending_o), 64'(32'h0000_0150));
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_enable", 64'(write_o.enable), 64'd0);
        check("midrst_pending", 64'(pending_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready_o), 64'b111);
        check("midrst_write", 64'(write_o), 64'd0);
        tick();
        tick();
        check("midrst_quiet", 64'(write_o.enable), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
